// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg: shared types for the fetch/LSU memory arbiter. Rev 1.0
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } bus_owner_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_e;

  // 69-bit memory command: addr, we, be, wdata
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo: small synchronous FIFO with full/empty flags. Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  push, pop;

  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter: shares one memory port between fetch and load/store. Rev 1.0
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        resp_orphan
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e  state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  mem_cmd_t    hold_q, hold_d;
  mem_cmd_t    cmd, instr_cmd, data_cmd;
  bus_owner_e  owner;
  logic        req, can_issue, any_req;
  logic        fifo_full, fifo_empty, push, pop;
  logic [0:0]  head_tag;

  assign instr_cmd = '{addr: instr_addr, we: 1'b0, be: 4'hF, wdata: 32'h0};
  assign data_cmd  = '{addr: data_addr, we: data_we, be: data_be, wdata: data_wdata};
  assign any_req   = instr_req | data_req;
  // Full flag alone gates issue, so a same-cycle response never feeds mem_req.
  assign can_issue = ~fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB;
      starve_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    hold_d   = hold_q;
    owner    = OWNER_INSTR;
    cmd      = '0;
    req      = 1'b0;
    unique case (state_q)
      ARB: begin
        if (data_req && !(starve_q == SW'(STARVE_LIMIT) && instr_req)) owner = OWNER_DATA;
        if (any_req) cmd = (owner == OWNER_DATA) ? data_cmd : instr_cmd;
        req = can_issue & any_req;
        if (req && !mem_gnt) begin
          state_d = (owner == OWNER_DATA) ? HOLD_D : HOLD_I;
          hold_d  = cmd;
        end
        if (req && mem_gnt && owner == OWNER_DATA && instr_req && starve_q != SW'(STARVE_LIMIT))
          starve_d = starve_q + SW'(1);
      end
      HOLD_I, HOLD_D: begin
        owner = (state_q == HOLD_D) ? OWNER_DATA : OWNER_INSTR;
        cmd   = hold_q;
        req   = can_issue;
        if (req && mem_gnt) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (req && mem_gnt && owner == OWNER_INSTR) starve_d = '0;
  end

  assign mem_req   = req;
  assign mem_addr  = cmd.addr;
  assign mem_we    = cmd.we;
  assign mem_be    = cmd.be;
  assign mem_wdata = cmd.wdata;

  assign push      = req & mem_gnt;
  assign instr_gnt = push & (owner == OWNER_INSTR);
  assign data_gnt  = push & (owner == OWNER_DATA);

  assign pop         = mem_valid & ~fifo_empty;
  assign resp_orphan = mem_valid & fifo_empty;
  assign instr_valid = pop & (bus_owner_e'(head_tag) == OWNER_INSTR);
  assign data_valid  = pop & (bus_owner_e'(head_tag) == OWNER_DATA);
  assign instr_rdata = mem_rdata;
  assign data_rdata  = mem_rdata;
  assign instr_err   = mem_err;
  assign data_err    = mem_err;

  sync_fifo #(
    .DEPTH      (MAX_OUTSTANDING),
    .DATA_WIDTH (1)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_ni  (reset_n),
    .clear_i (1'b0),
    .push_i  (push),
    .data_i  (owner),
    .pop_i   (pop),
    .data_o  (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter: directed scenarios plus randomized run against a queue model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int MAXO = 2;
  localparam int SLIM = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req, data_req, data_we, mem_gnt, mem_valid, mem_err;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;
  logic        instr_gnt, instr_valid, instr_err, data_gnt, data_valid, data_err;
  logic        mem_req, mem_we, resp_orphan;
  logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_valid(instr_valid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_valid(data_valid),
    .data_rdata(data_rdata), .data_err(data_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .resp_orphan(resp_orphan)
  );

  // Reference model: in-flight owner list, pending (stalled) command, lost-arbitration count
  int          mq[$];
  int          lost;
  bit          hv;
  int          ho;
  logic [31:0] ha, hd;
  logic        hw;
  logic [3:0]  hb;
  bit          e_req, e_ig, e_dg, e_iv, e_dv, e_orph;
  int          e_own;
  logic [31:0] e_addr, e_wd;
  logic        e_we;
  logic [3:0]  e_be;

  task automatic model_reset();
    mq.delete();
    lost = 0;
    hv   = 0;
  endtask

  task automatic model_eval();
    bit can;
    can  = (mq.size() < MAXO);
    e_iv = 0; e_dv = 0; e_orph = 0;
    if (hv) begin
      e_own = ho; e_req = can;
      e_addr = ha; e_we = hw; e_be = hb; e_wd = hd;
    end else begin
      e_own = (data_req && !(lost == SLIM && instr_req)) ? 1 : 0;
      e_req = can && (instr_req || data_req);
      if (e_own == 1) begin
        e_addr = data_addr; e_we = data_we; e_be = data_be; e_wd = data_wdata;
      end else begin
        e_addr = instr_addr; e_we = 1'b0; e_be = 4'hF; e_wd = 32'h0;
      end
    end
    e_ig = e_req && mem_gnt && e_own == 0;
    e_dg = e_req && mem_gnt && e_own == 1;
    if (mem_valid) begin
      if (mq.size() == 0) e_orph = 1;
      else if (mq[0] == 0) e_iv = 1;
      else e_dv = 1;
    end
  endtask

  task automatic model_commit();
    if (mem_valid && mq.size() > 0) void'(mq.pop_front());
    if (e_req && mem_gnt) begin
      mq.push_back(e_own);
      if (e_own == 0) lost = 0;
      else if (!hv && instr_req) lost = (lost < SLIM) ? lost + 1 : SLIM;
      hv = 0;
    end else if (e_req && !hv) begin
      hv = 1; ho = e_own; ha = e_addr; hw = e_we; hb = e_be; hd = e_wd;
    end
  endtask

  task automatic idle_inputs();
    instr_req = 0; instr_addr = '0;
    data_req = 0; data_addr = '0; data_we = 0; data_be = '0; data_wdata = '0;
    mem_gnt = 0; mem_valid = 0; mem_rdata = '0; mem_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    #4;
    checks++;
    if ({mem_req, instr_gnt, data_gnt, instr_valid, data_valid, resp_orphan} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {mem_req, instr_gnt, data_gnt, instr_valid, data_valid, resp_orphan});
    end
    checks++;
    if ({mem_addr, mem_we, mem_be, mem_wdata} !== 69'h0) begin
      failures++;
      $display("FAIL reset_cmd addr=%h we=%b be=%h wdata=%h exp=all zero", mem_addr, mem_we, mem_be, mem_wdata);
    end
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch_only();
    int gcount;
    do_reset();
    gcount = 0;
    mem_gnt = 1; instr_req = 1;
    for (int k = 0; k < 8; k++) begin
      instr_addr = 32'(4 * k);
      mem_valid  = (k > 0);
      mem_rdata  = 32'hA000 + 32'(k);
      #4;
      checks++;
      if (instr_gnt !== 1'b1 || mem_addr !== 32'(4 * k) || mem_be !== 4'hF || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
        failures++;
        $display("FAIL fetch_cmd k=%0d gnt=%b addr=%h be=%h we=%b exp gnt=1 addr=%h be=f we=0",
                 k, instr_gnt, mem_addr, mem_be, mem_we, 32'(4 * k));
      end
      checks++;
      if (data_valid !== 1'b0 || data_gnt !== 1'b0 || instr_valid !== (k > 0) || instr_rdata !== mem_rdata) begin
        failures++;
        $display("FAIL fetch_resp k=%0d dvalid=%b dgnt=%b ivalid=%b rdata=%h exp dvalid=0 dgnt=0 ivalid=%b rdata=%h",
                 k, data_valid, data_gnt, instr_valid, instr_rdata, (k > 0), mem_rdata);
      end
      if (instr_gnt === 1'b1) gcount++;
      tick();
    end
    instr_req = 0; mem_valid = 1;
    #4;
    checks++;
    if (instr_valid !== 1'b1 || data_valid !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_last ivalid=%b dvalid=%b mem_req=%b exp 1/0/0", instr_valid, data_valid, mem_req);
    end
    tick();
    mem_valid = 0;
    checks++;
    if (gcount != 8) begin
      failures++;
      $display("FAIL fetch_gnt_count got=%0d exp=8", gcount);
    end
  endtask

  task automatic test_priority();
    do_reset();
    instr_req = 1; instr_addr = 32'h40;
    data_req = 1; data_we = 1; data_addr = 32'h100; data_be = 4'h3; data_wdata = 32'hDEADBEEF;
    mem_gnt = 1;
    #4;
    checks++;
    if (data_gnt !== 1'b1 || instr_gnt !== 1'b0 || mem_we !== 1'b1 || mem_be !== 4'h3 ||
        mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL prio_data dgnt=%b ignt=%b we=%b be=%h addr=%h wd=%h exp 1/0/1/3/100/deadbeef",
               data_gnt, instr_gnt, mem_we, mem_be, mem_addr, mem_wdata);
    end
    tick();
    data_req = 0; data_we = 0;
    #4;
    checks++;
    if (instr_gnt !== 1'b1 || data_gnt !== 1'b0 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
      failures++;
      $display("FAIL prio_instr ignt=%b dgnt=%b addr=%h we=%b be=%h exp 1/0/40/0/f",
               instr_gnt, data_gnt, mem_addr, mem_we, mem_be);
    end
    tick();
    instr_req = 0; mem_gnt = 0; mem_valid = 1;
    #4;
    checks++;
    if (data_valid !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_resp1 dvalid=%b ivalid=%b exp 1/0", data_valid, instr_valid);
    end
    tick();
    #4;
    checks++;
    if (instr_valid !== 1'b1 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_resp2 ivalid=%b dvalid=%b exp 1/0", instr_valid, data_valid);
    end
    tick();
    mem_valid = 0;
  endtask

  task automatic test_starvation();
    bit exp_i;
    do_reset();
    instr_req = 1; instr_addr = 32'h80;
    data_req = 1; data_addr = 32'h200; data_be = 4'hF;
    mem_gnt = 1;
    for (int c = 0; c < 7; c++) begin
      mem_valid = (c > 0);
      exp_i = (c == 4);
      #4;
      checks++;
      if (instr_gnt !== exp_i || data_gnt !== !exp_i) begin
        failures++;
        $display("FAIL starve_gnt c=%0d ignt=%b dgnt=%b exp ignt=%b dgnt=%b", c, instr_gnt, data_gnt, exp_i, !exp_i);
      end
      checks++;
      if (instr_valid !== (c == 5) || data_valid !== (c >= 1 && c != 5)) begin
        failures++;
        $display("FAIL starve_resp c=%0d ivalid=%b dvalid=%b exp ivalid=%b dvalid=%b",
                 c, instr_valid, data_valid, (c == 5), (c >= 1 && c != 5));
      end
      tick();
    end
    instr_req = 0; data_req = 0; mem_gnt = 0;
    tick();
    mem_valid = 0;
  endtask

  task automatic test_hold();
    do_reset();
    instr_req = 1; instr_addr = 32'h20; mem_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        data_req = 1; data_addr = 32'h300; data_we = 1; data_be = 4'hF; data_wdata = 32'h55;
        instr_addr = 32'hBAD0;
      end
      if (c == 2) instr_req = 0;
      #4;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0 || mem_be !== 4'hF ||
          instr_gnt !== 1'b0 || data_gnt !== 1'b0) begin
        failures++;
        $display("FAIL hold_wait c=%0d req=%b addr=%h we=%b be=%h ignt=%b dgnt=%b exp 1/20/0/f/0/0",
                 c, mem_req, mem_addr, mem_we, mem_be, instr_gnt, data_gnt);
      end
      tick();
    end
    instr_req = 1; instr_addr = 32'h20; mem_gnt = 1;
    #4;
    checks++;
    if (instr_gnt !== 1'b1 || data_gnt !== 1'b0 || mem_addr !== 32'h20) begin
      failures++;
      $display("FAIL hold_gnt ignt=%b dgnt=%b addr=%h exp 1/0/20", instr_gnt, data_gnt, mem_addr);
    end
    tick();
    instr_req = 0;
    #4;
    checks++;
    if (data_gnt !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL hold_data dgnt=%b addr=%h we=%b exp 1/300/1", data_gnt, mem_addr, mem_we);
    end
    tick();
    #4;
    checks++;
    if (mem_req !== 1'b0 || data_gnt !== 1'b0) begin
      failures++;
      $display("FAIL full_block req=%b dgnt=%b exp 0/0", mem_req, data_gnt);
    end
    tick();
    mem_valid = 1;
    #4;
    checks++;
    if (instr_valid !== 1'b1 || data_valid !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL full_pop ivalid=%b dvalid=%b req=%b exp 1/0/0", instr_valid, data_valid, mem_req);
    end
    tick();
    mem_valid = 0; data_addr = 32'h304;
    #4;
    checks++;
    if (mem_req !== 1'b1 || data_gnt !== 1'b1 || mem_addr !== 32'h304) begin
      failures++;
      $display("FAIL refill req=%b dgnt=%b addr=%h exp 1/1/304", mem_req, data_gnt, mem_addr);
    end
    tick();
    data_req = 0; mem_valid = 1;
    #4;
    checks++;
    if (data_valid !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_d1 dvalid=%b ivalid=%b exp 1/0", data_valid, instr_valid);
    end
    tick();
    data_req = 1; data_addr = 32'h308;
    #4;
    checks++;
    if (data_valid !== 1'b1 || data_gnt !== 1'b1) begin
      failures++;
      $display("FAIL push_pop dvalid=%b dgnt=%b exp 1/1", data_valid, data_gnt);
    end
    tick();
    data_req = 0;
    #4;
    checks++;
    if (data_valid !== 1'b1 || resp_orphan !== 1'b0) begin
      failures++;
      $display("FAIL push_pop_cnt1 dvalid=%b orphan=%b exp 1/0", data_valid, resp_orphan);
    end
    tick();
    #4;
    checks++;
    if (resp_orphan !== 1'b1 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL push_pop_cnt2 orphan=%b dvalid=%b exp 1/0", resp_orphan, data_valid);
    end
    tick();
    mem_valid = 0; mem_gnt = 0; data_we = 0;
  endtask

  task automatic test_orphan_reset();
    do_reset();
    mem_valid = 1;
    #4;
    checks++;
    if (resp_orphan !== 1'b1 || instr_valid !== 1'b0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL orphan orphan=%b ivalid=%b dvalid=%b exp 1/0/0", resp_orphan, instr_valid, data_valid);
    end
    tick();
    mem_valid = 0;
    #4;
    checks++;
    if (resp_orphan !== 1'b0) begin
      failures++;
      $display("FAIL orphan_pulse orphan=%b exp 0", resp_orphan);
    end
    tick();
    instr_req = 1; data_req = 1; mem_gnt = 1;
    tick();
    tick();
    instr_req = 0; data_req = 0; mem_gnt = 0;
    #2;
    reset_n = 1'b0;
    #2;
    checks++;
    if ({mem_req, instr_gnt, data_gnt, instr_valid, data_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=00000", {mem_req, instr_gnt, data_gnt, instr_valid, data_valid});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_valid = 1;
    #4;
    checks++;
    if (resp_orphan !== 1'b1 || instr_valid !== 1'b0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_orphan orphan=%b ivalid=%b dvalid=%b exp 1/0/0", resp_orphan, instr_valid, data_valid);
    end
    tick();
    mem_valid = 0; instr_req = 1; mem_gnt = 1;
    #4;
    checks++;
    if (mem_req !== 1'b1 || instr_gnt !== 1'b1) begin
      failures++;
      $display("FAIL reset_issue req=%b ignt=%b exp 1/1", mem_req, instr_gnt);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [5:0] got_c, exp_c;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      instr_req  = ($urandom_range(0, 99) < 60);
      instr_addr = $urandom;
      data_req   = ($urandom_range(0, 99) < 55);
      data_addr  = $urandom;
      data_we    = 1'($urandom_range(0, 1));
      data_be    = 4'($urandom_range(0, 15));
      data_wdata = $urandom;
      mem_gnt    = ($urandom_range(0, 99) < 60);
      mem_valid  = ($urandom_range(0, 99) < 45);
      mem_rdata  = $urandom;
      mem_err    = 1'($urandom_range(0, 1));
      #4;
      model_eval();
      got_c = {mem_req, instr_gnt, data_gnt, instr_valid, data_valid, resp_orphan};
      exp_c = {e_req, e_ig, e_dg, e_iv, e_dv, e_orph};
      checks++;
      if (got_c !== exp_c) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b (req,ignt,dgnt,ivalid,dvalid,orphan)", cyc, got_c, exp_c);
      end
      if (e_req) begin
        checks++;
        if (mem_addr !== e_addr || mem_we !== e_we || mem_be !== e_be || mem_wdata !== e_wd) begin
          failures++;
          $display("FAIL rand_cmd cyc=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", cyc,
                   mem_addr, mem_we, mem_be, mem_wdata, e_addr, e_we, e_be, e_wd);
        end
      end
      checks++;
      if (instr_rdata !== mem_rdata || data_rdata !== mem_rdata || instr_err !== mem_err || data_err !== mem_err) begin
        failures++;
        $display("FAIL rand_pass cyc=%0d irdata=%h drdata=%h ierr=%b derr=%b exp rdata=%h err=%b",
                 cyc, instr_rdata, data_rdata, instr_err, data_err, mem_rdata, mem_err);
      end
      model_commit();
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_hold();
    test_orphan_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
